// File: rtl/gpu_pixel_writer_pkg.sv
// rtl/gpu_pixel_writer_pkg.sv - shared graphics-mode constants and pixel helpers for the pixel writer
package gpu_pixel_writer_pkg;

  localparam logic [1:0] GPU_MODE_1BPP = 2'b00;
  localparam logic [1:0] GPU_MODE_2BPP = 2'b01;
  localparam logic [1:0] GPU_MODE_4BPP = 2'b10;

  localparam int GPU_1BPP_WIDTH  = 320;
  localparam int GPU_1BPP_HEIGHT = 200;
  localparam int GPU_1BPP_BPR    = 40;
  localparam int GPU_2BPP_WIDTH  = 160;
  localparam int GPU_2BPP_HEIGHT = 200;
  localparam int GPU_2BPP_BPR    = 40;
  localparam int GPU_4BPP_WIDTH  = 160;
  localparam int GPU_4BPP_HEIGHT = 100;
  localparam int GPU_4BPP_BPR    = 80;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [3:0] color;
    logic       op;
    logic [1:0] mode;
  } pixel_cmd_t;

  // Invalid mode 2'b11 is always out of bounds, so it is rejected with the same path.
  function automatic logic pixel_in_bounds(input logic [1:0] mode, input logic [8:0] x,
                                           input logic [7:0] y);
    case (mode)
      GPU_MODE_1BPP: return (x < 9'(GPU_1BPP_WIDTH)) && (y < 8'(GPU_1BPP_HEIGHT));
      GPU_MODE_2BPP: return (x < 9'(GPU_2BPP_WIDTH)) && (y < 8'(GPU_2BPP_HEIGHT));
      GPU_MODE_4BPP: return (x < 9'(GPU_4BPP_WIDTH)) && (y < 8'(GPU_4BPP_HEIGHT));
      default:       return 1'b0;
    endcase
  endfunction

  function automatic logic [16:0] pixel_offset(input logic [1:0] mode, input logic [8:0] x,
                                               input logic [7:0] y);
    case (mode)
      GPU_MODE_1BPP: return 17'(y) * 17'(GPU_1BPP_BPR) + 17'(x >> 3);
      GPU_MODE_2BPP: return 17'(y) * 17'(GPU_2BPP_BPR) + 17'(x >> 2);
      GPU_MODE_4BPP: return 17'(y) * 17'(GPU_4BPP_BPR) + 17'(x >> 1);
      default:       return 17'd0;
    endcase
  endfunction

endpackage

// File: rtl/gpu_pixel_merge.sv
// rtl/gpu_pixel_merge.sv - combinational SET/XOR merge of one pixel field into a packed VRAM byte
module gpu_pixel_merge
  import gpu_pixel_writer_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [2:0] x_lo,
  input  logic [3:0] color,
  input  logic       op,
  input  logic [7:0] old_byte,
  output logic [7:0] new_byte
);

  logic [7:0] mask;
  logic [7:0] val;
  logic [2:0] sh2;

  assign sh2 = {x_lo[1:0], 1'b0};

  // Pixels are MSB-first, so pixel 0 of a byte always occupies the top field.
  always_comb begin
    mask = 8'h00;
    val  = 8'h00;
    case (mode)
      GPU_MODE_1BPP: begin
        mask = 8'h80 >> x_lo;
        val  = color[0] ? mask : 8'h00;
      end
      GPU_MODE_2BPP: begin
        mask = 8'hC0 >> sh2;
        val  = {color[1:0], 6'b0} >> sh2;
      end
      GPU_MODE_4BPP: begin
        mask = x_lo[0] ? 8'h0F : 8'hF0;
        val  = x_lo[0] ? {4'h0, color} : {color, 4'h0};
      end
      default: begin
        mask = 8'h00;
        val  = 8'h00;
      end
    endcase
  end

  assign new_byte = op ? (old_byte ^ val) : ((old_byte & ~mask) | val);

endmodule

// File: rtl/gpu_pixel_writer.sv
// rtl/gpu_pixel_writer.sv - single-pixel read-modify-write plotter into the packed VRAM framebuffer
module gpu_pixel_writer
  import gpu_pixel_writer_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              clk_pixel,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [8:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [3:0]        cmd_color,
  input  logic              cmd_op,
  input  logic [1:0]        gpu_mode,
  input  logic [ADDR_W-1:0] fb_base_addr,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_re,
  input  logic [7:0]        vram_rdata,
  output logic              vram_we,
  output logic [7:0]        vram_wdata,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CALC  = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  logic [2:0]        state_q, state_d;
  pixel_cmd_t        cmd_q, cmd_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        merged;
  logic              in_bounds;

  assign in_bounds = pixel_in_bounds(cmd_q.mode, cmd_q.x, cmd_q.y);

  // The merge sees vram_rdata directly; it is only registered in WAIT, where the read data is valid.
  gpu_pixel_merge u_merge (
    .mode     (cmd_q.mode),
    .x_lo     (cmd_q.x[2:0]),
    .color    (cmd_q.color),
    .op       (cmd_q.op),
    .old_byte (vram_rdata),
    .new_byte (merged)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    base_d  = base_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    re_d    = 1'b0;
    we_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_d.x     = cmd_x;
          cmd_d.y     = cmd_y;
          cmd_d.color = cmd_color;
          cmd_d.op    = cmd_op;
          cmd_d.mode  = gpu_mode;
          base_d      = fb_base_addr;
          state_d     = ST_CALC;
        end
      end
      ST_CALC: begin
        if (in_bounds) begin
          addr_d  = base_q + ADDR_W'(pixel_offset(cmd_q.mode, cmd_q.x, cmd_q.y));
          re_d    = 1'b1;
          state_d = ST_READ;
        end else begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end
      end
      ST_READ:  state_d = ST_WAIT;
      ST_WAIT: begin
        wdata_d = merged;
        we_d    = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      re_q    <= re_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign vram_addr  = addr_q;
  assign vram_re    = re_q;
  assign vram_we    = we_q;
  assign vram_wdata = wdata_q;
  assign done       = we_q;
  assign err        = err_q;

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// tb/tb_gpu_pixel_writer.sv - scoreboard bench for gpu_pixel_writer
module tb_gpu_pixel_writer;
  import gpu_pixel_writer_pkg::*;

  logic        clk_pixel = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [8:0]  cmd_x = '0;
  logic [7:0]  cmd_y = '0;
  logic [3:0]  cmd_color = '0;
  logic        cmd_op = 1'b0;
  logic [1:0]  gpu_mode = '0;
  logic [14:0] fb_base_addr = '0;
  logic [14:0] vram_addr;
  logic        vram_re;
  logic [7:0]  vram_rdata = 8'h00;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic        done;
  logic        err;

  logic [7:0]  mem_byte = 8'h00;

  int checks = 0;
  int fails  = 0;

  logic [14:0] exp_addr_q[$];
  logic [7:0]  exp_data_q[$];
  logic [14:0] obs_addr_q[$];
  logic [7:0]  obs_data_q[$];

  int obs_first_re, obs_first_we, obs_last_we, obs_first_err, obs_first_ready;
  int obs_n_re, obs_n_we, obs_overlap, obs_done_bad;

  gpu_pixel_writer #(.ADDR_W(15)) dut (
    .clk_pixel    (clk_pixel),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_x        (cmd_x),
    .cmd_y        (cmd_y),
    .cmd_color    (cmd_color),
    .cmd_op       (cmd_op),
    .gpu_mode     (gpu_mode),
    .fb_base_addr (fb_base_addr),
    .vram_addr    (vram_addr),
    .vram_re      (vram_re),
    .vram_rdata   (vram_rdata),
    .vram_we      (vram_we),
    .vram_wdata   (vram_wdata),
    .done         (done),
    .err          (err)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Registered VRAM: valid data only in the cycle after a read strobe, junk otherwise.
  always @(posedge clk_pixel) vram_rdata <= vram_re ? mem_byte : 8'hC3;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  function automatic logic [14:0] model_addr(input logic [1:0] mode, input int x, input int y,
                                             input logic [14:0] base);
    int bpr, ppb;
    bpr = (mode == GPU_MODE_4BPP) ? 80 : 40;
    ppb = (mode == GPU_MODE_1BPP) ? 8 : (mode == GPU_MODE_2BPP) ? 4 : 2;
    return 15'((int'(base) + y * bpr + x / ppb) % 32768);
  endfunction

  function automatic logic [7:0] model_data(input logic [1:0] mode, input int x, input int color,
                                            input logic op, input logic [7:0] old);
    int bpp, idx, sh, fmask, field, nf, oldi;
    bpp   = (mode == GPU_MODE_1BPP) ? 1 : (mode == GPU_MODE_2BPP) ? 2 : 4;
    idx   = x % (8 / bpp);
    sh    = 8 - bpp * (idx + 1);
    fmask = (1 << bpp) - 1;
    oldi  = int'(old);
    field = (oldi >> sh) & fmask;
    nf    = op ? (field ^ (color & fmask)) : (color & fmask);
    return 8'((oldi & ~(fmask << sh)) | (nf << sh));
  endfunction

  task automatic send_cmd(input logic [8:0] x, input logic [7:0] y, input logic [3:0] c,
                          input logic op, input logic [1:0] mode, input logic [14:0] base);
    int n;
    n = 0;
    @(negedge clk_pixel);
    while (!cmd_ready && n < 20) begin
      @(negedge clk_pixel);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_ready: cmd_ready=%0b required 1", cmd_ready);
    end
    cmd_x = x; cmd_y = y; cmd_color = c; cmd_op = op; gpu_mode = mode; fb_base_addr = base;
    cmd_valid = 1'b1;
    @(posedge clk_pixel);
    #1;
    cmd_valid = 1'b0;
    // Scramble the inputs so any use of them after accept would corrupt the result.
    cmd_x = 9'($urandom); cmd_y = 8'($urandom); cmd_color = 4'($urandom);
    cmd_op = ~op; gpu_mode = 2'b11; fb_base_addr = 15'($urandom);
  endtask

  task automatic observe(input int ncyc);
    obs_first_re = 0; obs_first_we = 0; obs_last_we = 0; obs_first_err = 0; obs_first_ready = 0;
    obs_n_re = 0; obs_n_we = 0; obs_overlap = 0; obs_done_bad = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk_pixel);
      if (vram_re) begin
        obs_n_re++;
        if (obs_first_re == 0) obs_first_re = c;
      end
      if (vram_we) begin
        obs_n_we++;
        if (obs_first_we == 0) obs_first_we = c;
        obs_last_we = c;
        obs_addr_q.push_back(vram_addr);
        obs_data_q.push_back(vram_wdata);
      end
      if (done !== vram_we) obs_done_bad++;
      if (vram_re && vram_we) obs_overlap++;
      if (err && obs_first_err == 0) obs_first_err = c;
      if (cmd_ready && obs_first_ready == 0) obs_first_ready = c;
    end
  endtask

  task automatic pop_pair(output logic [14:0] ga, output logic [14:0] ea,
                          output logic [7:0] gd, output logic [7:0] ed, output bit ok);
    ok = (obs_addr_q.size() > 0) && (exp_addr_q.size() > 0);
    ga = 'x; gd = 'x; ea = '0; ed = '0;
    if (obs_addr_q.size() > 0) begin ga = obs_addr_q.pop_front(); gd = obs_data_q.pop_front(); end
    if (exp_addr_q.size() > 0) begin ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front(); end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (cmd_ready !== 1'b1 || vram_addr !== 15'h0 || vram_re !== 1'b0 || vram_we !== 1'b0 ||
        vram_wdata !== 8'h00 || done !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: ready=%b addr=%h re=%b we=%b wdata=%h done=%b err=%b required 1 0000 0 0 00 0 0",
               cmd_ready, vram_addr, vram_re, vram_we, vram_wdata, done, err);
    end
    @(negedge clk_pixel);
    @(negedge clk_pixel);
    rst = 1'b0;
  endtask

  task automatic test_write(input string name, input logic [8:0] x, input logic [7:0] y,
                            input logic [3:0] c, input logic op, input logic [1:0] mode,
                            input logic [14:0] base, input logic [7:0] old,
                            input logic [14:0] want_addr, input logic [7:0] want_data);
    logic [14:0] ga, ea;
    logic [7:0]  gd, ed;
    bit ok;
    exp_addr_q.push_back(want_addr);
    exp_data_q.push_back(want_data);
    mem_byte = old;
    send_cmd(x, y, c, op, mode, base);
    observe(6);
    pop_pair(ga, ea, gd, ed, ok);
    checks++;
    if (!ok || ga !== ea) begin
      fails++;
      $display("FAIL %s_addr: got %h required %h", name, ga, ea);
    end
    checks++;
    if (!ok || gd !== ed) begin
      fails++;
      $display("FAIL %s_wdata: got %h required %h", name, gd, ed);
    end
  endtask

  task automatic test_4bpp_timing();
    test_write("corner4", 9'd159, 8'd99, 4'hA, 1'b0, GPU_MODE_4BPP, 15'h4000, 8'h12,
               15'h5F3F, 8'h1A);
    checks++;
    if (obs_first_re != 2 || obs_n_re != 1) begin
      fails++;
      $display("FAIL corner4_re: first cycle %0d count %0d required 2 and 1", obs_first_re, obs_n_re);
    end
    checks++;
    if (obs_first_we != 4 || obs_n_we != 1 || obs_done_bad != 0) begin
      fails++;
      $display("FAIL corner4_we_done: we cycle %0d count %0d done mismatches %0d required 4 1 0",
               obs_first_we, obs_n_we, obs_done_bad);
    end
    checks++;
    if (obs_first_ready != 5 || obs_overlap != 0) begin
      fails++;
      $display("FAIL corner4_ready: ready cycle %0d overlap %0d required 5 0", obs_first_ready, obs_overlap);
    end
  endtask

  task automatic test_rejects();
    logic [8:0]  rx[4] = '{9'd320, 9'd0, 9'd160, 9'd0};
    logic [7:0]  ry[4] = '{8'd0, 8'd0, 8'd0, 8'd100};
    logic [1:0]  rm[4] = '{GPU_MODE_1BPP, 2'b11, GPU_MODE_2BPP, GPU_MODE_4BPP};
    for (int i = 0; i < 4; i++) begin
      send_cmd(rx[i], ry[i], 4'h1, 1'b0, rm[i], 15'h0000);
      observe(5);
      checks++;
      if (obs_first_err != 2 || obs_n_re != 0 || obs_n_we != 0) begin
        fails++;
        $display("FAIL reject_%0d: err cycle %0d re %0d we %0d required 2 0 0",
                 i, obs_first_err, obs_n_re, obs_n_we);
      end
      checks++;
      if (obs_first_ready != 3) begin
        fails++;
        $display("FAIL reject_%0d_ready: ready cycle %0d required 3", i, obs_first_ready);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    mem_byte = 8'h55;
    send_cmd(9'd8, 8'd3, 4'h1, 1'b0, GPU_MODE_1BPP, 15'h0100);
    @(negedge clk_pixel);
    @(negedge clk_pixel);
    @(negedge clk_pixel);
    rst = 1'b1;
    #1;
    checks++;
    if (vram_we !== 1'b0 || vram_addr !== 15'h0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL midreset_state: we=%b addr=%h ready=%b required 0 0000 1", vram_we, vram_addr, cmd_ready);
    end
    @(negedge clk_pixel);
    rst = 1'b0;
    observe(6);
    checks++;
    if (obs_n_we != 0 || obs_first_ready != 1) begin
      fails++;
      $display("FAIL midreset_after: we count %0d ready cycle %0d required 0 1", obs_n_we, obs_first_ready);
    end
    obs_addr_q.delete();
    obs_data_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [14:0] ga, ea;
    logic [7:0]  gd, ed;
    bit ok;
    mem_byte = 8'h3C;
    exp_addr_q.push_back(model_addr(GPU_MODE_2BPP, 7, 10, 15'h0200));
    exp_data_q.push_back(model_data(GPU_MODE_2BPP, 7, 1, 1'b1, 8'h3C));
    exp_addr_q.push_back(model_addr(GPU_MODE_1BPP, 300, 199, 15'h0000));
    exp_data_q.push_back(model_data(GPU_MODE_1BPP, 300, 1, 1'b0, 8'h3C));
    @(negedge clk_pixel);
    cmd_x = 9'd7; cmd_y = 8'd10; cmd_color = 4'h1; cmd_op = 1'b1;
    gpu_mode = GPU_MODE_2BPP; fb_base_addr = 15'h0200;
    cmd_valid = 1'b1;
    @(posedge clk_pixel);
    #1;
    fork
      observe(12);
      begin
        int n;
        cmd_x = 9'd300; cmd_y = 8'd199; cmd_color = 4'h1; cmd_op = 1'b0;
        gpu_mode = GPU_MODE_1BPP; fb_base_addr = 15'h0000;
        n = 0;
        @(negedge clk_pixel);
        while (!cmd_ready && n < 10) begin
          @(negedge clk_pixel);
          n++;
        end
        @(posedge clk_pixel);
        #1;
        cmd_valid = 1'b0;
      end
    join
    checks++;
    if (obs_first_we != 4 || obs_last_we != 9 || obs_n_we != 2 || obs_overlap != 0) begin
      fails++;
      $display("FAIL b2b_timing: we cycles %0d/%0d count %0d overlap %0d required 4/9 2 0",
               obs_first_we, obs_last_we, obs_n_we, obs_overlap);
    end
    for (int i = 0; i < 2; i++) begin
      pop_pair(ga, ea, gd, ed, ok);
      checks++;
      if (!ok || ga !== ea || gd !== ed) begin
        fails++;
        $display("FAIL b2b_%0d: addr %h wdata %h required %h %h", i, ga, gd, ea, ed);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  modes[3] = '{GPU_MODE_1BPP, GPU_MODE_2BPP, GPU_MODE_4BPP};
    logic [14:0] ga, ea;
    logic [7:0]  gd, ed;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  m;
      int          x, y, c;
      logic        op;
      logic [14:0] base;
      m    = modes[$urandom_range(0, 2)];
      x    = $urandom_range(0, (m == GPU_MODE_1BPP) ? 319 : 159);
      y    = $urandom_range(0, (m == GPU_MODE_4BPP) ? 99 : 199);
      c    = $urandom_range(0, 15);
      op   = 1'($urandom);
      base = 15'($urandom);
      mem_byte = 8'($urandom);
      exp_addr_q.push_back(model_addr(m, x, y, base));
      exp_data_q.push_back(model_data(m, x, c, op, mem_byte));
      send_cmd(9'(x), 8'(y), 4'(c), op, m, base);
      observe(6);
      pop_pair(ga, ea, gd, ed, ok);
      checks++;
      if (!ok || ga !== ea || gd !== ed) begin
        fails++;
        $display("FAIL random_%0d: addr %h wdata %h required %h %h", i, ga, gd, ea, ed);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write("set1", 9'd10, 8'd1, 4'h1, 1'b0, GPU_MODE_1BPP, 15'h0000, 8'h00, 15'h0029, 8'h20);
    test_write("set2", 9'd5, 8'd2, 4'h2, 1'b0, GPU_MODE_2BPP, 15'h0000, 8'hFF, 15'h0051, 8'hEF);
    test_4bpp_timing();
    test_write("xor1", 9'd0, 8'd0, 4'h1, 1'b1, GPU_MODE_1BPP, 15'h0000, 8'h80, 15'h0000, 8'h00);
    test_write("wrap", 9'd256, 8'd0, 4'h1, 1'b0, GPU_MODE_1BPP, 15'h7FF0, 8'h00, 15'h0010, 8'h80);
    test_rejects();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    checks++;
    if (exp_addr_q.size() != 0 || obs_addr_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: expected left %0d observed left %0d required 0 0",
               exp_addr_q.size(), obs_addr_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
